// File: rtl/multi_debounce.sv
// Multi-channel button debouncer with per-channel press/release pulses and
// optional auto-repeat while a button is held.
module multi_debounce #(
  parameter int unsigned CH         = 4,
  parameter int unsigned STABLE_CNT = 1024,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned REPEAT_DLY = 25000,
  parameter int unsigned REPEAT_PER = 5000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] button_in,
  input  logic          repeat_en,
  output logic [CH-1:0] level_out,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] release_pulse,
  output logic          press_valid,
  output logic [3:0]    press_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } hold_state_e;

  localparam int unsigned DW   = $clog2(STABLE_CNT);
  localparam int unsigned HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned HW   = $clog2(HMAX + 1);

  logic [CH-1:0] w_raw;
  logic [CH-1:0] r_sync1, r_sync2, r_level;
  logic [CH-1:0] w_level;
  logic [DW-1:0] r_dcnt [CH];
  logic [DW-1:0] w_dcnt [CH];
  hold_state_e   r_state [CH];
  hold_state_e   w_state [CH];
  logic [HW-1:0] r_hcnt [CH];
  logic [HW-1:0] w_hcnt [CH];
  logic [CH-1:0] r_press, r_release;
  logic [CH-1:0] w_press, w_release;
  logic          r_valid, w_valid;
  logic [3:0]    r_idx, w_idx;

  assign w_raw = button_in ^ {CH{ACTIVE_LOW}};

  // State register: synchronisers, debounce/hold counters, registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_dcnt    <= '{default: '0};
      r_state   <= '{default: S_IDLE};
      r_hcnt    <= '{default: '0};
      r_press   <= '0;
      r_release <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level   <= w_level;
      r_dcnt    <= w_dcnt;
      r_state   <= w_state;
      r_hcnt    <= w_hcnt;
      r_press   <= w_press;
      r_release <= w_release;
      r_valid   <= w_valid;
      r_idx     <= w_idx;
    end
  end

  // Next state: debounce, hold/repeat FSM per channel, then priority encode
  always_comb begin
    w_level   = r_level;
    w_dcnt    = r_dcnt;
    w_state   = r_state;
    w_hcnt    = r_hcnt;
    w_press   = '0;
    w_release = '0;
    w_valid   = 1'b0;
    w_idx     = '0;

    for (int i = 0; i < int'(CH); i++) begin
      if (r_sync2[i] == r_level[i]) begin
        w_dcnt[i] = '0;
      end else if (r_dcnt[i] == DW'(STABLE_CNT - 1)) begin
        w_dcnt[i]    = '0;
        w_level[i]   = r_sync2[i];
        w_press[i]   = r_sync2[i];
        w_release[i] = ~r_sync2[i];
      end else begin
        w_dcnt[i] = r_dcnt[i] + DW'(1);
      end

      // A release or disabled repeat always wins over a pending repeat pulse
      if (!repeat_en || w_release[i]) begin
        w_state[i] = S_IDLE;
        w_hcnt[i]  = '0;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            if (w_press[i]) begin
              w_state[i] = S_DELAY;
              w_hcnt[i]  = '0;
            end
          end
          S_DELAY: begin
            if (r_hcnt[i] == HW'(REPEAT_DLY - 1)) begin
              w_state[i] = S_REPEAT;
              w_hcnt[i]  = '0;
              w_press[i] = 1'b1;
            end else begin
              w_hcnt[i] = r_hcnt[i] + HW'(1);
            end
          end
          S_REPEAT: begin
            if (r_hcnt[i] == HW'(REPEAT_PER - 1)) begin
              w_hcnt[i]  = '0;
              w_press[i] = 1'b1;
            end else begin
              w_hcnt[i] = r_hcnt[i] + HW'(1);
            end
          end
          default: begin
            w_state[i] = S_IDLE;
            w_hcnt[i]  = '0;
          end
        endcase
      end
    end

    w_valid = |w_press;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (w_press[i]) w_idx = 4'(i);
    end
  end

  assign level_out     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign press_valid   = r_valid;
  assign press_idx     = r_idx;

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent button channels (1..16).
REQ-002 SHALL have parameter STABLE_CNT, default 1024: consecutive clocks a synchronised input must differ from the debounced level before the level flips (2..2^20).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0: when 1, each raw input is inverted before synchronisation.
REQ-004 SHALL have parameter REPEAT_DLY, default 25000: held clocks after a press before the first auto-repeat pulse.
REQ-005 SHALL have parameter REPEAT_PER, default 5000: clocks between subsequent auto-repeat pulses.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port button_in, input, CH: raw, asynchronous, bouncing button inputs.
REQ-009 SHALL have port repeat_en, input, 1: enables auto-repeat on all channels.
REQ-010 SHALL have port level_out, output, CH: debounced level per channel (1 = pressed).
REQ-011 SHALL have port press_pulse, output, CH: one-clock pulse per debounced press or auto-repeat event.
REQ-012 SHALL have port release_pulse, output, CH: one-clock pulse per debounced release.
REQ-013 SHALL have port press_valid, output, 1: high when any press_pulse bit is high.
REQ-014 SHALL have port press_idx, output, 4: index of the lowest-numbered channel with press_pulse high; 0 when press_valid is low.

Function
REQ-015 SHALL pass each channel through a two-flip-flop synchroniser (sync1, sync2) after optional inversion.
REQ-016 SHALL keep a per-channel counter of width clog2(STABLE_CNT): cleared when sync2 equals level; otherwise incremented.
REQ-017 SHALL, on the edge where the counter equals STABLE_CNT-1 and sync2 still differs from level, set level to sync2 and clear the counter.
REQ-018 SHALL clear the counter on any clock where sync2 returns to level, so a bounce restarts the full STABLE_CNT interval.
REQ-019 SHALL therefore update level_out on the (STABLE_CNT+2)th rising edge after the first edge that samples a stable new input value.
REQ-020 SHALL assert press_pulse[i] for exactly the one clock following the edge where level[i] goes 0->1; release_pulse[i] likewise for 1->0.
REQ-021 SHALL run a per-channel hold counter with states IDLE, DELAY, REPEAT: IDLE->DELAY on a press; DELAY->REPEAT after REPEAT_DLY clocks, emitting one press_pulse; REPEAT emits one press_pulse every REPEAT_PER clocks.
REQ-022 SHALL return the hold state machine to IDLE and clear its counter on release, or whenever repeat_en is low; no repeat pulse occurs in the same clock as a release_pulse.
REQ-023 SHALL keep press_pulse and release_pulse of one channel mutually exclusive in any clock.
REQ-024 SHALL treat channels independently; simultaneous events on several channels all pulse, and press_idx reports the lowest index.
REQ-025 SHALL register press_valid and press_idx in the same clock as press_pulse (no extra latency).
REQ-026 SHALL saturate neither counter beyond its terminal value; the debounce counter holds at 0 while sync2 equals level.

Reset
REQ-027 SHALL, while reset is high, asynchronously clear sync1, sync2, level, all counters, and all hold state machines to IDLE.
REQ-028 SHALL drive level_out=0, press_pulse=0, release_pulse=0, press_valid=0, press_idx=0 during and immediately after reset.
REQ-029 SHALL, if reset asserts mid-debounce or mid-repeat, abandon that operation; after release, a held input (active after inversion) re-debounces from zero and produces a fresh press_pulse.

Verification (CH=4, STABLE_CNT=8, REPEAT_DLY=20, REPEAT_PER=6)
REQ-030 SHALL cover: button_in[0] steps 0->1 and holds -> level_out[0]=1 on edge 10 after first sampling; press_pulse[0] one clock; press_idx=0.
REQ-031 SHALL cover: button_in[1] toggles every 3 clocks for 40 clocks, then holds 1 -> no pulse during toggling; exactly one press_pulse[1], 10 edges after the final transition.
REQ-032 SHALL cover: repeat_en=1, button_in[2] held 50 clocks after level rises -> press pulses at offsets 0, 20, 26, 32, 38, 44; release -> one release_pulse[2], no further repeats.
REQ-033 SHALL cover: buttons 1 and 3 rise on the same edge -> both press_pulse bits high in the same clock; press_idx=1, press_valid=1.
REQ-034 SHALL cover: ACTIVE_LOW=1 with button_in all 1 from power-up -> no pulses; button_in[0] driven 0 -> press_pulse[0].
REQ-035 SHALL cover: reset pulsed 4 clocks into a debounce of held button_in[3]=1 -> all outputs 0 during reset; press_pulse[3] 10 edges after reset deasserts.
